pkt_ff_wr_arb: RTL and testbench
================================

Name: pkt_ff_wr_arb

Overview:
- Packet-granular write-side arbiter and sequencer for the async packet FIFO.
- Shares one FIFO write port (valid/sop/eop/error/data) between NUM_SRC packet sources, using round-robin arbitration.
- Holds a grant from SOP to EOP, back-pressures on FIFO full, and aborts stalled packets with an error beat. An error beat makes the FIFO rewind its write pointer to the packet start.
- Counts dropped packets.

Parameters:
- NUM_SRC, 4, number of requesting sources (2..8).
- DATA_W, 32, data width per beat.
- STALL_MAX, 255, consecutive full-stall cycles inside a packet before abort (1..2^16-1).
- CNT_W, 16, width of drop counter.
- SEL_W, $clog2(NUM_SRC), derived; not overridden.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- src_valid  in  NUM_SRC  per-source beat valid
- src_sop  in  NUM_SRC  per-source start of packet
- src_eop  in  NUM_SRC  per-source end of packet
- src_error  in  NUM_SRC  per-source packet error (qualified by valid)
- src_data  in  NUM_SRC*DATA_W  packed source data; source i at [i*DATA_W +: DATA_W]
- src_ready  out  NUM_SRC  per-source beat accept (combinational)
- ff_full  in  1  FIFO full, write-clock domain
- ff_valid  out  1  FIFO write valid
- ff_sop  out  1  FIFO sop
- ff_eop  out  1  FIFO eop
- ff_error  out  1  FIFO error / rewind request
- ff_data  out  DATA_W  FIFO write data
- drop_cnt  out  CNT_W  saturating count of error-terminated packets

Behaviour:
- Reset:
  - state=IDLE; rr pointer=NUM_SRC-1, so source 0 has first priority.
  - All ff_* outputs 0, src_ready 0, drop_cnt 0, stall counter 0.
  - Reset mid-packet discards the packet silently. No error beat is emitted.
- Beat handshake: a beat transfers on src_valid[i] & src_ready[i]. The ff_* outputs are registered: 1-cycle latency from accept to ff_valid. ff_valid is 0 in every cycle with no accept and no abort beat.
- State IDLE:
  - src_ready=0.
  - Eligible sources: src_valid[i] & src_sop[i]. Valid beats without sop are ignored (not eligible, not accepted).
  - If any source is eligible, grant the first eligible index after the rr pointer, cyclically. Latch grant; next state XFER.
- State XFER:
  - src_ready[grant] = ~ff_full; all other ready bits 0.
  - An accepted beat is copied to ff_* with sop/eop/error/data as presented.
  - Accepted eop: next state IDLE; rr pointer = grant.
  - Accepted error without eop: next state DROP. Error with eop: IDLE.
  - Either error case increments drop_cnt once.
  - Stall counter: increments each cycle ff_full=1; clears on any accepted beat.
  - Stall counter reaching STALL_MAX: emit one beat ff_valid=1, ff_error=1, sop=eop=0, data=0 (the error beat does not need a free slot). drop_cnt+1; next state DROP.
- State DROP:
  - src_ready[grant]=1 regardless of ff_full. Beats are discarded; no ff_valid.
  - Accepted eop: IDLE; rr pointer = grant.
- Single-beat packet (sop & eop in one beat): IDLE -> XFER -> IDLE, with exactly one ff beat.
- In XFER, a beat with sop before the prior eop is passed through unchanged. Sources are required to frame correctly; the arbiter does not check framing.
- drop_cnt saturates at 2^CNT_W-1.
- An arbiter decision needs one IDLE cycle. Minimum packet-to-packet gap on ff_* is 1 cycle.

Decomposition:
- Package pkt_ff_arb_pkg holds:
  - typedef enum {IDLE, XFER, DROP} state_t;
  - a function that rotates the request vector by the rr pointer.
- Sub-module pkt_rr_arb: combinational round-robin selector.
  - Inputs: req[NUM_SRC], last[SEL_W].
  - Outputs: gnt_idx[SEL_W], gnt_vld.
  - Instantiated once.

Test Plan:
- Sources 0 and 2 each present a 3-beat packet at reset exit -> source 0 packet on ff_* first (sop,d,eop), then after 1 idle cycle source 2; drop_cnt=0.
- All 4 sources continuously present 1-beat packets -> ff grant order 0,1,2,3,0, with each ff beat 2 cycles apart.
- Source 1 sends a 4-beat packet with error on beat 2 -> ff_* shows beats 1-2 (beat 2 error=1); beats 3-4 accepted but not forwarded; drop_cnt=1.
- ff_full held 10 cycles mid-packet, STALL_MAX=255 -> src_ready low for 10 cycles; packet completes intact; no error beat.
- ff_full held, STALL_MAX=4 -> after 4 stall cycles one ff beat with error=1; remainder drained with ready=1; drop_cnt=1.
- rst_n asserted mid-packet, released, new packet from source 3 -> all outputs 0 during reset; source 3 packet forwarded clean from IDLE.

Source files
------------

// File: rtl/pkt_ff_arb_pkg.sv
// Shared types and helpers for the packet FIFO write-side arbiter.
package pkt_ff_arb_pkg;

    localparam int unsigned MAX_SRC   = 8;
    localparam int unsigned MAX_SEL_W = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        XFER = 2'd1,
        DROP = 2'd2
    } state_t;

    // Rotate the request vector so bit 0 is the source right after 'last'.
    function automatic logic [MAX_SRC-1:0] rr_rotate(
        input logic [MAX_SRC-1:0] req,
        input int unsigned        num,
        input int unsigned        last
    );
        logic [MAX_SRC-1:0] rot;
        rot = '0;
        for (int unsigned k = 0; k < MAX_SRC; k++) begin
            if (k < num) begin
                rot[MAX_SEL_W'(k)] = req[MAX_SEL_W'((last + 1 + k) % num)];
            end
        end
        return rot;
    endfunction

endpackage

// File: rtl/pkt_rr_arb.sv
// Combinational round-robin selector: first requester after 'last', cyclically.
module pkt_rr_arb
    import pkt_ff_arb_pkg::*;
#(
    parameter  int unsigned NUM_SRC = 4,
    localparam int unsigned SEL_W   = $clog2(NUM_SRC)
) (
    input  logic [NUM_SRC-1:0] req,
    input  logic [SEL_W-1:0]   last,
    output logic [SEL_W-1:0]   gnt_idx,
    output logic               gnt_vld
);

    logic [MAX_SRC-1:0] req_ext;
    logic [MAX_SRC-1:0] rot;

    // Pick the lowest set bit of the rotated vector and map it back to a source index.
    always_comb begin
        req_ext                = '0;
        req_ext[NUM_SRC-1:0]   = req;
        rot                    = rr_rotate(req_ext, NUM_SRC, 32'(last));
        gnt_vld                = 1'b0;
        gnt_idx                = '0;
        for (int unsigned k = 0; k < MAX_SRC; k++) begin
            if (!gnt_vld && rot[MAX_SEL_W'(k)]) begin
                gnt_vld = 1'b1;
                gnt_idx = SEL_W'((32'(last) + 1 + k) % NUM_SRC);
            end
        end
    end

endmodule

// File: rtl/pkt_ff_wr_arb.sv
// Packet-granular round-robin arbiter sharing one FIFO write port between sources.
module pkt_ff_wr_arb
    import pkt_ff_arb_pkg::*;
#(
    parameter  int unsigned NUM_SRC   = 4,
    parameter  int unsigned DATA_W    = 32,
    parameter  int unsigned STALL_MAX = 255,
    parameter  int unsigned CNT_W     = 16,
    localparam int unsigned SEL_W     = $clog2(NUM_SRC)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_SRC-1:0]        src_valid,
    input  logic [NUM_SRC-1:0]        src_sop,
    input  logic [NUM_SRC-1:0]        src_eop,
    input  logic [NUM_SRC-1:0]        src_error,
    input  logic [NUM_SRC*DATA_W-1:0] src_data,
    output logic [NUM_SRC-1:0]        src_ready,
    input  logic                      ff_full,
    output logic                      ff_valid,
    output logic                      ff_sop,
    output logic                      ff_eop,
    output logic                      ff_error,
    output logic [DATA_W-1:0]         ff_data,
    output logic [CNT_W-1:0]          drop_cnt
);

    localparam int unsigned STALL_W = 16;

    state_t             state;
    logic [SEL_W-1:0]   grant;
    logic [SEL_W-1:0]   last;
    logic [STALL_W-1:0] stall_cnt;
    logic [SEL_W-1:0]   arb_idx;
    logic               arb_vld;
    logic [NUM_SRC-1:0] elig;
    logic               accept;
    logic               stall_hit;
    logic [CNT_W-1:0]   drop_nxt;
    logic [DATA_W-1:0]  data_arr [NUM_SRC];

    for (genvar i = 0; i < NUM_SRC; i++) begin : g_unpack
        assign data_arr[i] = src_data[i*DATA_W +: DATA_W];
    end

    // Only a valid start-of-packet beat may win arbitration.
    assign elig = src_valid & src_sop;

    pkt_rr_arb #(
        .NUM_SRC (NUM_SRC)
    ) u_rr (
        .req     (elig),
        .last    (last),
        .gnt_idx (arb_idx),
        .gnt_vld (arb_vld)
    );

    // Ready goes only to the granted source; DROP drains regardless of FIFO space.
    always_comb begin
        src_ready = '0;
        case (state)
            XFER:    src_ready[grant] = ~ff_full;
            DROP:    src_ready[grant] = 1'b1;
            default: src_ready = '0;
        endcase
    end

    assign accept    = src_valid[grant] & src_ready[grant];
    assign stall_hit = (stall_cnt == STALL_W'(STALL_MAX - 1));
    assign drop_nxt  = (drop_cnt == {CNT_W{1'b1}}) ? drop_cnt : drop_cnt + CNT_W'(1);

    // Packet sequencer: grant hold, beat forwarding, stall abort and drop drain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            grant     <= '0;
            last      <= SEL_W'(NUM_SRC - 1);
            stall_cnt <= '0;
            drop_cnt  <= '0;
            ff_valid  <= 1'b0;
            ff_sop    <= 1'b0;
            ff_eop    <= 1'b0;
            ff_error  <= 1'b0;
            ff_data   <= '0;
        end else begin
            ff_valid <= 1'b0;
            ff_sop   <= 1'b0;
            ff_eop   <= 1'b0;
            ff_error <= 1'b0;
            ff_data  <= '0;
            case (state)
                IDLE: begin
                    stall_cnt <= '0;
                    if (arb_vld) begin
                        grant <= arb_idx;
                        state <= XFER;
                    end
                end
                XFER: begin
                    if (accept) begin
                        ff_valid  <= 1'b1;
                        ff_sop    <= src_sop[grant];
                        ff_eop    <= src_eop[grant];
                        ff_error  <= src_error[grant];
                        ff_data   <= data_arr[grant];
                        stall_cnt <= '0;
                        if (src_error[grant]) begin
                            drop_cnt <= drop_nxt;
                        end
                        if (src_eop[grant]) begin
                            state <= IDLE;
                            last  <= grant;
                        end else if (src_error[grant]) begin
                            state <= DROP;
                        end
                    end else if (ff_full) begin
                        if (stall_hit) begin
                            // Abort beat makes the FIFO rewind; it needs no free slot.
                            ff_valid  <= 1'b1;
                            ff_error  <= 1'b1;
                            stall_cnt <= '0;
                            drop_cnt  <= drop_nxt;
                            state     <= DROP;
                        end else begin
                            stall_cnt <= stall_cnt + STALL_W'(1);
                        end
                    end
                end
                DROP: begin
                    if (accept && src_eop[grant]) begin
                        state <= IDLE;
                        last  <= grant;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pkt_ff_wr_arb.sv
// Scoreboard bench for pkt_ff_wr_arb: source queues drive beats, expected FIFO beats are checked in order.
module tb_pkt_ff_wr_arb;

    localparam int unsigned NUM_SRC = 4;
    localparam int unsigned DATA_W  = 32;
    localparam int unsigned CNT_W   = 16;

    typedef struct packed {
        logic              sop;
        logic              eop;
        logic              err;
        logic [DATA_W-1:0] data;
    } beat_t;

    logic                      clk   = 1'b0;
    logic                      rst_n = 1'b1;
    logic [NUM_SRC-1:0]        src_valid = '0;
    logic [NUM_SRC-1:0]        src_sop   = '0;
    logic [NUM_SRC-1:0]        src_eop   = '0;
    logic [NUM_SRC-1:0]        src_error = '0;
    logic [NUM_SRC*DATA_W-1:0] src_data  = '0;
    logic                      full_a = 1'b0;
    logic                      full_b = 1'b0;
    logic                      use_b  = 1'b0;

    logic [NUM_SRC-1:0] rdy_a, rdy_b;
    logic               val_a, sop_a, eop_a, err_a;
    logic               val_b, sop_b, eop_b, err_b;
    logic [DATA_W-1:0]  data_a, data_b;
    logic [CNT_W-1:0]   drop_a, drop_b;

    logic [NUM_SRC-1:0] src_ready;
    logic               m_valid, m_sop, m_eop, m_err;
    logic [DATA_W-1:0]  m_data;
    logic [CNT_W-1:0]   m_drop;

    assign src_ready = use_b ? rdy_b  : rdy_a;
    assign m_valid   = use_b ? val_b  : val_a;
    assign m_sop     = use_b ? sop_b  : sop_a;
    assign m_eop     = use_b ? eop_b  : eop_a;
    assign m_err     = use_b ? err_b  : err_a;
    assign m_data    = use_b ? data_b : data_a;
    assign m_drop    = use_b ? drop_b : drop_a;

    pkt_ff_wr_arb #(.NUM_SRC(NUM_SRC), .DATA_W(DATA_W), .STALL_MAX(255), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .src_valid(src_valid), .src_sop(src_sop), .src_eop(src_eop),
        .src_error(src_error), .src_data(src_data), .src_ready(rdy_a), .ff_full(full_a),
        .ff_valid(val_a), .ff_sop(sop_a), .ff_eop(eop_a), .ff_error(err_a), .ff_data(data_a),
        .drop_cnt(drop_a)
    );

    pkt_ff_wr_arb #(.NUM_SRC(NUM_SRC), .DATA_W(DATA_W), .STALL_MAX(4), .CNT_W(CNT_W)) dut_s (
        .clk(clk), .rst_n(rst_n), .src_valid(src_valid), .src_sop(src_sop), .src_eop(src_eop),
        .src_error(src_error), .src_data(src_data), .src_ready(rdy_b), .ff_full(full_b),
        .ff_valid(val_b), .ff_sop(sop_b), .ff_eop(eop_b), .ff_error(err_b), .ff_data(data_b),
        .drop_cnt(drop_b)
    );

    beat_t       srcq [NUM_SRC][$];
    beat_t       exp_q[$];
    int          vcyc[$];
    int unsigned acc_cnt [NUM_SRC];
    int          cyc    = 0;
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Expected beat of packet p from source s; error flagged on beat err_at.
    function automatic beat_t beat_of(input int s, input int p, input int len, input int err_at, input int b);
        beat_t r;
        r.sop  = (b == 0);
        r.eop  = (b == len - 1);
        r.err  = (b == err_at);
        r.data = {8'hA0, 8'(s), 8'(p), 8'(b)};
        return r;
    endfunction

    task automatic load_pkt(input int s, input int p, input int len, input int err_at);
        for (int b = 0; b < len; b++) srcq[s].push_back(beat_of(s, p, len, err_at, b));
    endtask

    task automatic expect_beats(input int s, input int p, input int len, input int err_at, input int n);
        for (int b = 0; b < n; b++) exp_q.push_back(beat_of(s, p, len, err_at, b));
    endtask

    // Source driver: pops beats accepted in the previous cycle, presents the next head.
    initial begin : driver
        logic [NUM_SRC-1:0] acc;
        beat_t              tmp;
        forever begin
            @(negedge clk);
            acc = src_valid & src_ready;
            @(posedge clk);
            #1;
            for (int i = 0; i < NUM_SRC; i++) begin
                if (acc[i] && rst_n && srcq[i].size() > 0) begin
                    tmp = srcq[i].pop_front();
                    acc_cnt[i]++;
                end
                if (srcq[i].size() > 0) begin
                    src_valid[i] = 1'b1;
                    src_sop[i]   = srcq[i][0].sop;
                    src_eop[i]   = srcq[i][0].eop;
                    src_error[i] = srcq[i][0].err;
                    src_data[i*DATA_W +: DATA_W] = srcq[i][0].data;
                end else begin
                    src_valid[i] = 1'b0;
                    src_sop[i]   = 1'b0;
                    src_eop[i]   = 1'b0;
                    src_error[i] = 1'b0;
                    src_data[i*DATA_W +: DATA_W] = '0;
                end
            end
        end
    end

    // FIFO-side monitor: every write beat must match the scoreboard head.
    initial begin : monitor
        beat_t e;
        forever begin
            @(negedge clk);
            if (rst_n && m_valid) begin
                vcyc.push_back(cyc);
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL sb_unexpected: got sop=%0b eop=%0b err=%0b data=%h, expected no beat",
                             m_sop, m_eop, m_err, m_data);
                end else begin
                    e = exp_q.pop_front();
                    if (m_sop !== e.sop || m_eop !== e.eop || m_err !== e.err || m_data !== e.data) begin
                        errors++;
                        $display("FAIL sb_beat: got sop=%0b eop=%0b err=%0b data=%h, expected sop=%0b eop=%0b err=%0b data=%h",
                                 m_sop, m_eop, m_err, m_data, e.sop, e.eop, e.err, e.data);
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic flush_all();
        for (int i = 0; i < NUM_SRC; i++) begin
            srcq[i].delete();
            acc_cnt[i] = 0;
        end
        exp_q.delete();
        vcyc.delete();
        full_a = 1'b0;
        full_b = 1'b0;
    endtask

    task automatic reset_now();
        rst_n = 1'b0;
        flush_all();
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #2;
        reset_now();
    endtask

    task automatic wait_acc(input int s, input int n, input int maxc, input string nm);
        int k;
        k = 0;
        while (acc_cnt[s] < n && k < maxc) begin
            @(posedge clk);
            #2;
            k++;
        end
        if (acc_cnt[s] < n) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: accepted %0d beats, expected %0d", nm, acc_cnt[s], n);
        end
    endtask

    task automatic wait_drain(input int maxc, input string nm);
        int  k;
        bit  done;
        k    = 0;
        done = 1'b0;
        while (!done && k < maxc) begin
            @(posedge clk);
            #2;
            k++;
            done = (exp_q.size() == 0);
            for (int i = 0; i < NUM_SRC; i++) if (srcq[i].size() != 0) done = 1'b0;
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL %s_drain: %0d expected beats left, expected 0", nm, exp_q.size());
        end
        repeat (3) @(posedge clk);
        #2;
    endtask

    task automatic check_idle_outputs(input string nm);
        checks++;
        if (m_valid !== 1'b0 || m_sop !== 1'b0 || m_eop !== 1'b0 || m_err !== 1'b0 ||
            m_data !== '0 || src_ready !== '0 || m_drop !== '0) begin
            errors++;
            $display("FAIL %s: got valid=%0b sop=%0b eop=%0b err=%0b data=%h ready=%b drop=%0d, expected all 0",
                     nm, m_valid, m_sop, m_eop, m_err, m_data, src_ready, m_drop);
        end
    endtask

    task automatic test_reset();
        #1 rst_n = 1'b0;
        @(negedge clk);
        check_idle_outputs("reset_a");
        checks++;
        if (val_b !== 1'b0 || rdy_b !== '0 || drop_b !== '0) begin
            errors++;
            $display("FAIL reset_b: got valid=%0b ready=%b drop=%0d, expected 0", val_b, rdy_b, drop_b);
        end
        @(posedge clk);
        #2;
        rst_n = 1'b1;
    endtask

    task automatic test_two_sources();
        load_pkt(0, 1, 3, -1);
        load_pkt(2, 1, 3, -1);
        expect_beats(0, 1, 3, -1, 3);
        expect_beats(2, 1, 3, -1, 3);
        wait_drain(100, "two_src");
        checks++;
        if (vcyc.size() != 6) begin
            errors++;
            $display("FAIL two_src_beats: got %0d beats, expected 6", vcyc.size());
        end else begin
            checks++;
            if (vcyc[3] - vcyc[2] != 2 || vcyc[1] - vcyc[0] != 1) begin
                errors++;
                $display("FAIL two_src_gap: got gaps %0d/%0d, expected 1/2", vcyc[1] - vcyc[0], vcyc[3] - vcyc[2]);
            end
        end
        checks++;
        if (m_drop !== 16'd0) begin
            errors++;
            $display("FAIL two_src_drop: got %0d, expected 0", m_drop);
        end
    endtask

    task automatic test_rr_order();
        int bad;
        do_reset();
        for (int p = 0; p < 2; p++) for (int s = 0; s < NUM_SRC; s++) load_pkt(s, p, 1, -1);
        for (int p = 0; p < 2; p++) for (int s = 0; s < NUM_SRC; s++) expect_beats(s, p, 1, -1, 1);
        wait_drain(100, "rr");
        checks++;
        if (vcyc.size() != 8) begin
            errors++;
            $display("FAIL rr_beats: got %0d beats, expected 8", vcyc.size());
        end else begin
            bad = 0;
            for (int k = 1; k < 8; k++) if (vcyc[k] - vcyc[k-1] != 2) bad++;
            checks++;
            if (bad != 0) begin
                errors++;
                $display("FAIL rr_spacing: got %0d gaps not equal to 2, expected 0", bad);
            end
        end
    endtask

    task automatic test_error_drop();
        do_reset();
        load_pkt(1, 2, 4, 1);
        expect_beats(1, 2, 4, 1, 2);
        wait_drain(100, "err");
        checks++;
        if (acc_cnt[1] != 4) begin
            errors++;
            $display("FAIL err_accepted: got %0d, expected 4", acc_cnt[1]);
        end
        checks++;
        if (m_drop !== 16'd1) begin
            errors++;
            $display("FAIL err_drop_cnt: got %0d, expected 1", m_drop);
        end
        load_pkt(0, 3, 1, -1);
        expect_beats(0, 3, 1, -1, 1);
        wait_drain(50, "err_after");
    endtask

    task automatic test_stall_no_abort();
        int low;
        do_reset();
        load_pkt(0, 4, 5, -1);
        expect_beats(0, 4, 5, -1, 5);
        wait_acc(0, 1, 20, "stall");
        full_a = 1'b1;
        low = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (src_ready[0] === 1'b0) low++;
        end
        @(posedge clk);
        #2;
        full_a = 1'b0;
        checks++;
        if (low != 10 || acc_cnt[0] != 1) begin
            errors++;
            $display("FAIL stall_ready: got %0d low cycles with %0d accepted, expected 10 with 1", low, acc_cnt[0]);
        end
        wait_drain(50, "stall");
        checks++;
        if (m_drop !== 16'd0) begin
            errors++;
            $display("FAIL stall_drop: got %0d, expected 0", m_drop);
        end
    endtask

    task automatic test_stall_abort();
        beat_t eb;
        do_reset();
        use_b = 1'b1;
        load_pkt(2, 5, 6, -1);
        expect_beats(2, 5, 6, -1, 1);
        eb.sop  = 1'b0;
        eb.eop  = 1'b0;
        eb.err  = 1'b1;
        eb.data = '0;
        exp_q.push_back(eb);
        wait_acc(2, 1, 20, "abort");
        full_b = 1'b1;
        wait_acc(2, 6, 40, "abort_drain");
        repeat (3) @(posedge clk);
        #2;
        checks++;
        if (exp_q.size() != 0 || vcyc.size() != 2) begin
            errors++;
            $display("FAIL abort_beats: got %0d beats with %0d pending, expected 2 with 0", vcyc.size(), exp_q.size());
        end else begin
            checks++;
            if (vcyc[1] - vcyc[0] != 4) begin
                errors++;
                $display("FAIL abort_timing: got %0d cycles to error beat, expected 4", vcyc[1] - vcyc[0]);
            end
        end
        checks++;
        if (m_drop !== 16'd1) begin
            errors++;
            $display("FAIL abort_drop_cnt: got %0d, expected 1", m_drop);
        end
        full_b = 1'b0;
        do_reset();
        use_b = 1'b0;
    endtask

    task automatic test_reset_mid_packet();
        do_reset();
        load_pkt(0, 6, 5, -1);
        expect_beats(0, 6, 5, -1, 2);
        wait_acc(0, 2, 20, "rst_mid");
        rst_n = 1'b0;
        flush_all();
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            check_idle_outputs("rst_mid_outputs");
        end
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        load_pkt(3, 7, 2, -1);
        expect_beats(3, 7, 2, -1, 2);
        wait_drain(50, "rst_new");
        checks++;
        if (vcyc.size() != 2 || m_drop !== 16'd0) begin
            errors++;
            $display("FAIL rst_new_pkt: got %0d beats drop=%0d, expected 2 beats drop=0", vcyc.size(), m_drop);
        end
    endtask

    initial begin : main
        for (int i = 0; i < NUM_SRC; i++) acc_cnt[i] = 0;
        test_reset();
        test_two_sources();
        test_rr_order();
        test_error_drop();
        test_stall_no_abort();
        test_stall_abort();
        test_reset_mid_packet();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
